// File: rtl/saikoro_roll_ctrl.sv
// Push-button front end for the dice counter: synchronise and debounce the button,
// spin while held, then decelerate with growing enable intervals and flag the final face.
module saikoro_roll_ctrl #(
    parameter int DEB_CYCLES  = 4,
    parameter int SPIN_DIV    = 1,
    parameter int SLOW_START  = 2,
    parameter int SLOW_STEP   = 2,
    parameter int SLOW_PULSES = 5,
    parameter int CW          = 16
) (
    input  logic ck,
    input  logic reset,
    input  logic btn,
    output logic enable,
    output logic rolling,
    output logic settled
);

    localparam logic [CW-1:0] DEB_LAST    = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] SPIN_LAST   = CW'(SPIN_DIV - 1);
    localparam logic [CW-1:0] START_IV    = CW'(SLOW_START);
    localparam logic [CW-1:0] PULSES_LAST = CW'(SLOW_PULSES - 1);
    localparam logic [CW-1:0] ONE         = CW'(1);
    localparam logic [CW:0]   STEP_EXT    = (CW+1)'(SLOW_STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        SLOW = 2'd2,
        DONE = 2'd3
    } state_t;

    logic [1:0]    sync_reg;
    logic          btn_db_reg;
    logic [CW-1:0] deb_cnt_reg;

    state_t        state_reg, state_next;
    logic [CW-1:0] div_reg, div_next;
    logic [CW-1:0] wait_reg, wait_next;
    logic [CW-1:0] interval_reg, interval_next;
    logic [CW-1:0] pulses_reg, pulses_next;
    logic          enable_reg, enable_next;
    logic          rolling_reg, rolling_next;
    logic          settled_reg, settled_next;

    logic [CW:0]   interval_sum;
    logic [CW-1:0] interval_sat;

    // Two-flop synchroniser: sync_reg[1] is the only copy of btn the logic may use.
    always_ff @(posedge ck) begin
        if (reset) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], btn};
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge ck) begin
        if (reset) begin
            btn_db_reg  <= 1'b0;
            deb_cnt_reg <= '0;
        end else if (sync_reg[1] == btn_db_reg) begin
            deb_cnt_reg <= '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
            btn_db_reg  <= sync_reg[1];
            deb_cnt_reg <= '0;
        end else begin
            deb_cnt_reg <= deb_cnt_reg + ONE;
        end
    end

    assign interval_sum = {1'b0, interval_reg} + STEP_EXT;
    assign interval_sat = interval_sum[CW] ? '1 : interval_sum[CW-1:0];

    always_comb begin
        state_next    = state_reg;
        div_next      = div_reg;
        wait_next     = wait_reg;
        interval_next = interval_reg;
        pulses_next   = pulses_reg;
        enable_next   = 1'b0;
        settled_next  = 1'b0;
        rolling_next  = (state_reg == SPIN) || (state_reg == SLOW);

        case (state_reg)
            IDLE: begin
                if (btn_db_reg) begin
                    state_next = SPIN;
                    div_next   = '0;
                end
            end
            SPIN: begin
                if (!btn_db_reg) begin
                    state_next    = SLOW;
                    interval_next = START_IV;
                    wait_next     = '0;
                    pulses_next   = '0;
                end else begin
                    enable_next = (div_reg == '0);
                    div_next    = (div_reg == SPIN_LAST) ? '0 : div_reg + ONE;
                end
            end
            SLOW: begin
                // A fresh press wins over a pulse falling due in the same cycle.
                if (btn_db_reg) begin
                    state_next    = SPIN;
                    div_next      = '0;
                    wait_next     = '0;
                    interval_next = '0;
                    pulses_next   = '0;
                end else if (wait_reg == interval_reg - ONE) begin
                    enable_next   = 1'b1;
                    wait_next     = '0;
                    interval_next = interval_sat;
                    pulses_next   = pulses_reg + ONE;
                    if (pulses_reg == PULSES_LAST) begin
                        state_next = DONE;
                    end
                end else begin
                    wait_next = wait_reg + ONE;
                end
            end
            DONE: begin
                settled_next = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            state_reg    <= IDLE;
            div_reg      <= '0;
            wait_reg     <= '0;
            interval_reg <= '0;
            pulses_reg   <= '0;
            enable_reg   <= 1'b0;
            rolling_reg  <= 1'b0;
            settled_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            div_reg      <= div_next;
            wait_reg     <= wait_next;
            interval_reg <= interval_next;
            pulses_reg   <= pulses_next;
            enable_reg   <= enable_next;
            rolling_reg  <= rolling_next;
            settled_reg  <= settled_next;
        end
    end

    assign enable  = enable_reg;
    assign rolling = rolling_reg;
    assign settled = settled_reg;

endmodule

// File: tb/tb_saikoro_roll_ctrl.sv
// Scoreboard bench for saikoro_roll_ctrl: a timeline model predicts every enable,
// settled and rolling-edge event; a monitor compares each DUT event against the queue.
`timescale 1ns/1ps
module tb_saikoro_roll_ctrl;

    localparam int DEB         = 4;
    localparam int SPIN_DIV    = 1;
    localparam int SLOW_START  = 2;
    localparam int SLOW_STEP   = 2;
    localparam int SLOW_PULSES = 5;
    localparam int CW          = 16;
    localparam int NMAX        = 3000;
    localparam int IV_MAX      = (2 ** CW) - 1;

    logic ck = 1'b0;
    logic reset;
    logic btn;
    logic enable;
    logic rolling;
    logic settled;

    saikoro_roll_ctrl #(
        .DEB_CYCLES (DEB),
        .SPIN_DIV   (SPIN_DIV),
        .SLOW_START (SLOW_START),
        .SLOW_STEP  (SLOW_STEP),
        .SLOW_PULSES(SLOW_PULSES),
        .CW         (CW)
    ) dut (
        .ck     (ck),
        .reset  (reset),
        .btn    (btn),
        .enable (enable),
        .rolling(rolling),
        .settled(settled)
    );

    always #5 ck = ~ck;

    // Index n = value applied at / observed after rising edge n.
    bit b_at[0:NMAX];
    bit r_at[0:NMAX];
    bit s1a[0:NMAX];
    bit s2a[0:NMAX];
    bit dba[0:NMAX];
    bit en_x[0:NMAX];
    bit rl_x[0:NMAX];
    bit st_x[0:NMAX];

    typedef struct packed {
        int cyc;
        bit en;
        bit rl;
        bit st;
    } ev_t;

    ev_t sb_q[$];
    int  errors = 0;
    int  checks = 0;
    int  pos = 0;
    int  exp_en_total = 0;

    task automatic seg(input bit lvl, input int len, input bit rst);
        for (int i = 0; i < len; i++) begin
            if (pos < NMAX) begin
                pos++;
                b_at[pos] = lvl;
                r_at[pos] = rst;
            end
        end
    endtask

    // Debounced level: flips once the last DEB synchronised samples all disagree
    // and none of them predates the previous flip or reset.
    function automatic void model_debounce();
        int last_evt;
        bit all_diff;
        last_evt = 0;
        s1a[0] = 1'b0;
        s2a[0] = 1'b0;
        dba[0] = 1'b0;
        for (int n = 1; n <= NMAX; n++) begin
            if (r_at[n]) begin
                s1a[n] = 1'b0;
                s2a[n] = 1'b0;
                dba[n] = 1'b0;
                last_evt = n;
                continue;
            end
            s1a[n] = b_at[n];
            s2a[n] = s1a[n-1];
            dba[n] = dba[n-1];
            if (n - last_evt >= DEB) begin
                all_diff = 1'b1;
                for (int e = n - DEB + 1; e <= n; e++) begin
                    if (s2a[e-1] == dba[n-1]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    dba[n] = ~dba[n-1];
                    last_evt = n;
                end
            end
        end
    endfunction

    // Roll timeline: spin enables on a fixed stride from spin start, slow pulses at
    // absolute target edges that grow by SLOW_STEP, settle one edge after the last.
    function automatic void model_roll();
        int phase;
        int s;
        int tgt;
        int iv;
        int np;
        bit done_p;
        phase = 0; s = 0; tgt = 0; iv = 0; np = 0; done_p = 1'b0;
        for (int n = 1; n <= NMAX; n++) begin
            en_x[n] = 1'b0;
            rl_x[n] = 1'b0;
            st_x[n] = 1'b0;
            if (r_at[n]) begin
                phase = 0;
                done_p = 1'b0;
                continue;
            end
            if (phase == 0) begin
                if (done_p) begin
                    st_x[n] = 1'b1;
                    done_p = 1'b0;
                end else if (dba[n-1]) begin
                    phase = 1;
                    s = n;
                end
            end else if (phase == 1) begin
                rl_x[n] = 1'b1;
                if (!dba[n-1]) begin
                    phase = 2;
                    iv = SLOW_START;
                    tgt = n + iv;
                    np = 0;
                end else begin
                    en_x[n] = (((n - s - 1) % SPIN_DIV) == 0);
                end
            end else begin
                rl_x[n] = 1'b1;
                if (dba[n-1]) begin
                    phase = 1;
                    s = n;
                end else if (n == tgt) begin
                    en_x[n] = 1'b1;
                    np++;
                    if (np == SLOW_PULSES) begin
                        phase = 0;
                        done_p = 1'b1;
                    end else begin
                        iv = (iv + SLOW_STEP > IV_MAX) ? IV_MAX : iv + SLOW_STEP;
                        tgt = n + iv;
                    end
                end
            end
        end
    endfunction

    initial begin
        bit   lvl;
        int   pick;
        bit   prev;
        ev_t  ev;

        reset = 1'b1;
        btn   = 1'b0;

        // Directed: reset/idle, glitch, spin+decelerate, re-press in slow, reset in slow,
        // button held through reset.
        seg(1'b0, 2, 1'b1);
        seg(1'b0, 50, 1'b0);
        seg(1'b1, 3, 1'b0);
        seg(1'b0, 20, 1'b0);
        seg(1'b1, 20, 1'b0);
        seg(1'b0, 60, 1'b0);
        seg(1'b1, 20, 1'b0);
        seg(1'b0, 9, 1'b0);
        seg(1'b1, 15, 1'b0);
        seg(1'b0, 60, 1'b0);
        seg(1'b1, 20, 1'b0);
        seg(1'b0, 20, 1'b0);
        seg(1'b0, 2, 1'b1);
        seg(1'b0, 40, 1'b0);
        seg(1'b1, 3, 1'b1);
        seg(1'b1, 20, 1'b0);
        seg(1'b0, 60, 1'b0);
        while (pos < NMAX - 150) begin
            lvl  = 1'($urandom_range(0, 1));
            pick = int'($urandom_range(0, 19));
            if (pick == 0)      seg(lvl, int'($urandom_range(1, 2)), 1'b1);
            else if (pick < 8)  seg(lvl, int'($urandom_range(1, 6)), 1'b0);
            else                seg(lvl, int'($urandom_range(8, 60)), 1'b0);
        end
        seg(1'b0, NMAX - pos, 1'b0);

        model_debounce();
        model_roll();

        prev = 1'b0;
        for (int n = 1; n <= NMAX; n++) begin
            if (en_x[n] || st_x[n] || (rl_x[n] != prev)) begin
                ev.cyc = n;
                ev.en  = en_x[n];
                ev.rl  = rl_x[n];
                ev.st  = st_x[n];
                sb_q.push_back(ev);
            end
            if (en_x[n]) exp_en_total++;
            prev = rl_x[n];
        end

        fork
            begin : driver
                for (int n = 1; n <= NMAX; n++) begin
                    btn   = b_at[n];
                    reset = r_at[n];
                    @(posedge ck);
                    #2;
                end
            end
            begin : monitor
                bit  prev_rl;
                int  dice;
                ev_t got;
                prev_rl = 1'b0;
                dice = 1;
                for (int n = 1; n <= NMAX; n++) begin
                    @(posedge ck);
                    #1;
                    if (n == 2) begin
                        checks++;
                        if ({enable, rolling, settled} !== 3'b000) begin
                            errors++;
                            $display("FAIL reset_state: got en/rl/st=%b%b%b required 000",
                                     enable, rolling, settled);
                        end
                    end
                    if (enable === 1'b1) dice = (dice == 6) ? 1 : dice + 1;
                    if (enable !== 1'b0 || settled !== 1'b0 || rolling !== prev_rl) begin
                        checks++;
                        if (sb_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_event: cyc=%0d got en=%b rl=%b st=%b required no event",
                                     n, enable, rolling, settled);
                        end else begin
                            got = sb_q.pop_front();
                            if (got.cyc != n || got.en !== enable || got.rl !== rolling || got.st !== settled) begin
                                errors++;
                                $display("FAIL event: got cyc=%0d en=%b rl=%b st=%b required cyc=%0d en=%b rl=%b st=%b",
                                         n, enable, rolling, settled, got.cyc, got.en, got.rl, got.st);
                            end else begin
                                $display("txn cyc=%0d en=%b rl=%b st=%b ok", n, enable, rolling, settled);
                            end
                        end
                    end
                    prev_rl = (rolling === 1'b1);
                end
                checks++;
                if (dice != (exp_en_total % 6) + 1) begin
                    errors++;
                    $display("FAIL dice_final: got %0d required %0d", dice, (exp_en_total % 6) + 1);
                end
            end
        join

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d expected events never seen, first at cyc=%0d",
                     sb_q.size(), sb_q[0].cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
